// File: rtl/imm_encoder_pkg.sv
// Shared constants for the rotated-immediate encoder: word and operand
// widths, rotation-count width and the FSM state encodings.
package imm_encoder_pkg;

  localparam int unsigned WORD_WIDTH            = 32;
  localparam int unsigned SHIFTER_OPERAND_WIDTH = 12;
  localparam int unsigned IMM_ENC_ROT_WIDTH     = 4;
  localparam int unsigned IMM_ENC_IMM_WIDTH     = 8;

  localparam logic [IMM_ENC_ROT_WIDTH-1:0] IMM_ENC_ROT_MAX = '1;

  typedef enum logic [1:0] {
    IMM_ENC_IDLE   = 2'd0,
    IMM_ENC_SEARCH = 2'd1,
    IMM_ENC_DONE   = 2'd2
  } imm_enc_state_e;

endpackage

// File: rtl/imm_rot_check.sv
// One rotate-and-test step: rotate the target left by 2*rot and report
// whether the result fits in the low 8 bits.
module imm_rot_check
  import imm_encoder_pkg::*;
(
  input  logic [WORD_WIDTH-1:0]        target,
  input  logic [IMM_ENC_ROT_WIDTH-1:0] rot,
  output logic                         match,
  output logic [IMM_ENC_IMM_WIDTH-1:0] imm8
);

  logic [2*WORD_WIDTH-1:0] doubled;
  logic [WORD_WIDTH-1:0]   candidate;

  // Rotate-left via a doubled word; the upper half holds the rotated value.
  always_comb begin
    doubled   = {target, target} << {rot, 1'b0};
    candidate = WORD_WIDTH'(doubled >> WORD_WIDTH);
    match     = (candidate[WORD_WIDTH-1:IMM_ENC_IMM_WIDTH] == '0);
    imm8      = candidate[IMM_ENC_IMM_WIDTH-1:0];
  end

endmodule

// File: rtl/imm_encoder.sv
// Operand-2 rotated-immediate encoder: sequentially searches rot 0..15 for
// the smallest rotation that turns the value into an 8-bit immediate.
// Optional feature macro: IMM_ENC_NEGATE_EN adds a second pass over ~value
// and the inverted output.
module imm_encoder
  import imm_encoder_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [WORD_WIDTH-1:0]            value,
  output logic                             busy,
  output logic                             done,
  output logic                             encodable,
  output logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand
`ifdef IMM_ENC_NEGATE_EN
  ,
  output logic                             inverted
`endif
);

  imm_enc_state_e                 state_q;
  logic [IMM_ENC_ROT_WIDTH-1:0]   rot_q;
  logic [WORD_WIDTH-1:0]          target_q;
  logic                           rot_match;
  logic [IMM_ENC_IMM_WIDTH-1:0]   rot_imm8;
`ifdef IMM_ENC_NEGATE_EN
  logic                           pass_q;
`endif

  imm_rot_check u_rot_check (
    .target (target_q),
    .rot    (rot_q),
    .match  (rot_match),
    .imm8   (rot_imm8)
  );

  // Search FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IMM_ENC_IDLE;
      rot_q           <= '0;
      target_q        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      encodable       <= 1'b0;
      shifter_operand <= '0;
`ifdef IMM_ENC_NEGATE_EN
      pass_q          <= 1'b0;
      inverted        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IMM_ENC_IDLE, IMM_ENC_DONE: begin
          if (start) begin
            state_q  <= IMM_ENC_SEARCH;
            busy     <= 1'b1;
            target_q <= value;
            rot_q    <= '0;
`ifdef IMM_ENC_NEGATE_EN
            pass_q   <= 1'b0;
`endif
          end else begin
            state_q <= IMM_ENC_IDLE;
          end
        end
        IMM_ENC_SEARCH: begin
          if (rot_match) begin
            state_q         <= IMM_ENC_DONE;
            busy            <= 1'b0;
            done            <= 1'b1;
            encodable       <= 1'b1;
            shifter_operand <= {rot_q, rot_imm8};
`ifdef IMM_ENC_NEGATE_EN
            inverted        <= pass_q;
`endif
          end else if (rot_q == IMM_ENC_ROT_MAX) begin
`ifdef IMM_ENC_NEGATE_EN
            if (!pass_q) begin
              // Plain value exhausted; retry on its complement.
              pass_q   <= 1'b1;
              target_q <= ~target_q;
              rot_q    <= '0;
            end else begin
              state_q         <= IMM_ENC_DONE;
              busy            <= 1'b0;
              done            <= 1'b1;
              encodable       <= 1'b0;
              shifter_operand <= '0;
              inverted        <= 1'b0;
            end
`else
            state_q         <= IMM_ENC_DONE;
            busy            <= 1'b0;
            done            <= 1'b1;
            encodable       <= 1'b0;
            shifter_operand <= '0;
`endif
          end else begin
            rot_q <= rot_q + IMM_ENC_ROT_WIDTH'(1);
          end
        end
        default: begin
          state_q <= IMM_ENC_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed literal cases plus a
// randomized run checked every cycle against a brute-force reference.
module tb_imm_encoder;

`ifdef IMM_ENC_NEGATE_EN
  localparam bit NEG = 1'b1;
`else
  localparam bit NEG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        encodable;
  logic [11:0] shifter_operand;
`ifdef IMM_ENC_NEGATE_EN
  logic        inverted;
`endif

  imm_encoder dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .value           (value),
    .busy            (busy),
    .done            (done),
    .encodable       (encodable),
    .shifter_operand (shifter_operand)
`ifdef IMM_ENC_NEGATE_EN
    ,
    .inverted        (inverted)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  // Brute force: which (rot, imm8) decodes to v (or ~v), smallest rot first.
  function automatic void ref_encode(input logic [31:0] v, output bit enc,
                                     output logic [11:0] op, output bit inv,
                                     output int lat);
    logic [31:0] t;
    enc = 1'b0; op = 12'h000; inv = 1'b0;
    lat = NEG ? 32 : 16;
    for (int p = 0; p < (NEG ? 2 : 1); p++) begin
      t = (p == 0) ? v : ~v;
      for (int r = 0; r < 16; r++) begin
        for (int i = 0; i < 256; i++) begin
          if (ror32(32'(i), 2 * r) == t) begin
            enc = 1'b1;
            op  = {4'(r), 8'(i)};
            inv = (p == 1);
            lat = 16 * p + r + 1;
            return;
          end
        end
      end
    end
  endfunction

  // Reference model, advanced on every rising edge.
  int          cyc = 0;
  int          m_done_cyc = 0;
  bit          m_busy = 0, m_done = 0, m_enc = 0, m_inv = 0;
  logic [11:0] m_op = 12'h000;
  bit          e_enc, e_inv;
  logic [11:0] e_op;
  int          e_lat;
  bit          accept;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst === 1'b1) begin
      m_busy = 0; m_done = 0; m_enc = 0; m_op = 12'h000; m_inv = 0;
    end else begin
      accept = (start === 1'b1) && !m_busy;
      m_done = 0;
      if (m_busy && cyc == m_done_cyc) begin
        m_busy = 0; m_done = 1;
        m_enc = e_enc; m_op = e_op; m_inv = e_inv;
      end
      if (accept) begin
        ref_encode(value, e_enc, e_op, e_inv, e_lat);
        m_busy     = 1;
        m_done_cyc = cyc + e_lat;
      end
    end
  end

  // Every-cycle comparison against the model; results checked while idle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      if (!m_busy) begin
        check("encodable", 32'(encodable), 32'(m_enc));
        check("shifter_operand", 32'(shifter_operand), 32'(m_op));
`ifdef IMM_ENC_NEGATE_EN
        check("inverted", 32'(inverted), 32'(m_inv));
`endif
      end
    end
  end

  task automatic drive_start(input logic [31:0] v);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #2;
    start = 1'b0;
    value = $urandom;
  endtask

  // Waits for done; lat counts edges after the accepting edge.
  task automatic wait_done(output int lat, output bit seen);
    lat = -1;
    seen = 1'b0;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_case(input string name, input logic [31:0] v, input int x_lat,
                          input bit x_enc, input logic [11:0] x_op, input bit x_inv);
    int  lat;
    bit  seen;
    bit  r_enc, r_inv;
    logic [11:0] r_op;
    int  r_lat;
    ref_encode(v, r_enc, r_op, r_inv, r_lat);
    check({name, "_model_lat"}, 32'(r_lat), 32'(x_lat));
    check({name, "_model_op"}, 32'(r_op), 32'(x_op));
    check({name, "_model_inv"}, 32'(r_inv), 32'(x_inv));
    drive_start(v);
    wait_done(lat, seen);
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'(x_lat));
    check({name, "_encodable"}, 32'(encodable), 32'(x_enc));
    check({name, "_operand"}, 32'(shifter_operand), 32'(x_op));
`ifdef IMM_ENC_NEGATE_EN
    check({name, "_inverted"}, 32'(inverted), 32'(x_inv));
`endif
  endtask

  function automatic logic [31:0] rand_value();
    logic [31:0] b;
    b = ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
    case ($urandom_range(0, 3))
      0:       return b;
      1:       return ~b;
      2:       return $urandom;
      default: return ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(0, 511));
    endcase
  endfunction

  initial begin
    int  lat;
    bit  seen;
    rst = 1'b1; start = 1'b0; value = 32'h0;
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_encodable", 32'(encodable), 32'd0);
    check("reset_operand", 32'(shifter_operand), 32'd0);

    run_case("v_ff",       32'h000000FF, 1,  1'b1, 12'h0FF, 1'b0);
    run_case("v_ff000000", 32'hFF000000, 5,  1'b1, 12'h4FF, 1'b0);
    run_case("v_104",      32'h00000104, 16, 1'b1, 12'hF41, 1'b0);
    run_case("v_102",      32'h00000102, NEG ? 32 : 16, 1'b0, 12'h000, 1'b0);
    if (NEG) run_case("v_ffffff00", 32'hFFFFFF00, 17, 1'b1, 12'h0FF, 1'b1);
    else     run_case("v_ffffff00", 32'hFFFFFF00, 16, 1'b0, 12'h000, 1'b0);
    run_case("v_zero",     32'h00000000, 1,  1'b1, 12'h000, 1'b0);

    // Reset in the middle of a search, then a fresh request.
    drive_start(32'h00000104);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_encodable", 32'(encodable), 32'd0);
    check("abort_operand", 32'(shifter_operand), 32'd0);
    run_case("after_abort", 32'h000000FF, 1, 1'b1, 12'h0FF, 1'b0);

    // Start while busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    drive_start(32'h00000104);
    repeat (3) @(negedge clk);
    start = 1'b1;
    value = 32'h000000FF;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done(lat, seen);
    check("busy_ignore_seen", 32'(seen), 32'd1);
    check("busy_ignore_latency", 32'(lat), 32'd13);
    check("busy_ignore_operand", 32'(shifter_operand), 32'h0F41);
    run_case("start_in_done", 32'hFF000000, 5, 1'b1, 12'h4FF, 1'b0);

    // Randomized traffic; the every-cycle compare does the checking.
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk);
      #2;
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 2) == 0);
      value = rand_value();
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
